// File: rtl/dma_xfer_ctrl_if.sv
// rtl/dma_xfer_ctrl_if.sv - MMIO, request-port and buffer signals of the DMA loopback controller
interface dma_xfer_ctrl_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int SIZE_WIDTH = 17
);
    logic                  go;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [SIZE_WIDTH-1:0] size;
    logic                  done;
    logic                  rd_req_en;
    logic [ADDR_WIDTH-1:0] rd_req_addr;
    logic                  rd_req_full;
    logic                  rd_rsp_valid;
    logic                  buf_empty;
    logic                  buf_rd_en;
    logic                  wr_req_en;
    logic [ADDR_WIDTH-1:0] wr_req_addr;
    logic                  wr_req_full;
    logic [63:0]           counter_read_latency;
    logic [63:0]           counter_read;
    logic [63:0]           counter_total;

    // Controller side
    modport master (
        input  go, rd_addr, wr_addr, size, rd_req_full, rd_rsp_valid, buf_empty, wr_req_full,
        output done, rd_req_en, rd_req_addr, buf_rd_en, wr_req_en, wr_req_addr,
               counter_read_latency, counter_read, counter_total
    );

    // Host / memory side
    modport slave (
        output go, rd_addr, wr_addr, size, rd_req_full, rd_rsp_valid, buf_empty, wr_req_full,
        input  done, rd_req_en, rd_req_addr, buf_rd_en, wr_req_en, wr_req_addr,
               counter_read_latency, counter_read, counter_total
    );
endinterface

// File: rtl/dma_xfer_ctrl.sv
// rtl/dma_xfer_ctrl.sv - credit-based DMA loopback transfer sequencer with cycle counters
module dma_xfer_ctrl #(
    parameter int ADDR_WIDTH      = 64,
    parameter int SIZE_WIDTH      = 17,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic           clk,
    input  logic           rst,
    dma_xfer_ctrl_if.master bus
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] rd_base, wr_base;
    logic [SIZE_WIDTH-1:0] size_q, rd_count, wr_count, rsp_count;
    logic [CW-1:0]         credits;
    logic                  lat_started, lat_ended;
    logic [63:0]           cnt_lat, cnt_rd, cnt_tot;
    logic                  go_accept, rd_fire, wr_fire, last_wr, rsp_ok, done_q;

    // go is only honoured outside RUN; a response with nothing outstanding is dropped
    assign go_accept = bus.go && (state != S_RUN);
    assign rsp_ok    = (state == S_RUN) && bus.rd_rsp_valid && (rsp_count != rd_count);
    assign last_wr   = wr_fire && ((wr_count + SIZE_WIDTH'(1)) == size_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: zero-length transfers complete without entering RUN
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (bus.go) state_nxt = (bus.size == '0) ? S_DONE : S_RUN;
            S_RUN:          if (last_wr) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // Request issue decisions; data for a write is the buffer head, so pop and write coincide
    always_comb begin
        rd_fire = 1'b0;
        wr_fire = 1'b0;
        if (state == S_RUN) begin
            rd_fire = (rd_count < size_q) && !bus.rd_req_full && (credits != '0);
            wr_fire = !bus.buf_empty && !bus.wr_req_full && (wr_count < size_q);
        end
        done_q = (state == S_DONE);
    end

    assign bus.done                 = done_q;
    assign bus.rd_req_en            = rd_fire;
    assign bus.buf_rd_en            = wr_fire;
    assign bus.wr_req_en            = wr_fire;
    assign bus.rd_req_addr          = rd_base + (ADDR_WIDTH'(rd_count) << 6);
    assign bus.wr_req_addr          = wr_base + (ADDR_WIDTH'(wr_count) << 6);
    assign bus.counter_read_latency = cnt_lat;
    assign bus.counter_read         = cnt_rd;
    assign bus.counter_total        = cnt_tot;

    // Latched transfer parameters, progress counts, credits and performance counters
    always_ff @(posedge clk) begin
        if (rst || go_accept) begin
            rd_base     <= rst ? '0 : bus.rd_addr;
            wr_base     <= rst ? '0 : bus.wr_addr;
            size_q      <= rst ? '0 : bus.size;
            rd_count    <= '0;
            wr_count    <= '0;
            rsp_count   <= '0;
            credits     <= CW'(MAX_OUTSTANDING);
            lat_started <= 1'b0;
            lat_ended   <= 1'b0;
            cnt_lat     <= '0;
            cnt_rd      <= '0;
            cnt_tot     <= '0;
        end else if (state == S_RUN) begin
            if (rd_fire) rd_count  <= rd_count + SIZE_WIDTH'(1);
            if (wr_fire) wr_count  <= wr_count + SIZE_WIDTH'(1);
            if (rsp_ok)  rsp_count <= rsp_count + SIZE_WIDTH'(1);
            case ({rd_fire, wr_fire})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: credits <= credits;
            endcase
            cnt_tot <= cnt_tot + 64'd1;
            if (rsp_count < size_q) cnt_rd <= cnt_rd + 64'd1;
            // Latency window opens on the first issue cycle and closes on the first response
            if (!lat_started) begin
                if (rd_fire) begin
                    lat_started <= 1'b1;
                    cnt_lat     <= cnt_lat + 64'd1;
                end
            end else if (!lat_ended) begin
                if (rsp_ok) lat_ended <= 1'b1;
                else        cnt_lat   <= cnt_lat + 64'd1;
            end
        end
    end

    a_credit_max: assert property (@(posedge clk) disable iff (rst)
        credits <= CW'(MAX_OUTSTANDING));

    a_rsp_legal: assert property (@(posedge clk) disable iff (rst)
        !(state == S_RUN && bus.rd_rsp_valid && rsp_count == rd_count));
endmodule
